wut_timer: RTL



---
 rtl/wut_timer.sv | 79 +++++++
 1 files changed

// File: rtl/wut_timer.sv
// wut_timer: always-on wake-up timer, responder side of the PMU start handshake.
// Ports: perm_clk/perm_rstb (async active-low) clock and reset; perm_wut_en enable;
// perm_wut_period/perm_wut_prescaler count setup sampled at start; perm_wut_start_req/ack
// handshake; perm_wut_it one-cycle expiry pulse; perm_wut_remaining (WUT_READBACK_EN only).
module wut_timer #(
  parameter int CNT_WIDTH = 8,
  parameter int PSC_WIDTH = 4
) (
  input  logic                 perm_clk,
  input  logic                 perm_rstb,
  input  logic                 perm_wut_en,
  input  logic [CNT_WIDTH-1:0] perm_wut_period,
  input  logic [PSC_WIDTH-1:0] perm_wut_prescaler,
  input  logic                 perm_wut_start_req,
  output logic                 perm_wut_start_ack,
  output logic                 perm_wut_it
`ifdef WUT_READBACK_EN
  ,
  output logic [CNT_WIDTH-1:0] perm_wut_remaining
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIRE} state_t;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [PSC_WIDTH-1:0] psc, psc_n, psc_rld, psc_rld_n;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    psc_n     = psc;
    psc_rld_n = psc_rld;
    if (!perm_wut_en) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      psc_n   = '0;
    end else begin
      case (state)
        S_IDLE: if (perm_wut_start_req) begin
          state_n   = S_RUN;
          cnt_n     = (perm_wut_period == '0) ? CNT_WIDTH'(1) : perm_wut_period;
          psc_n     = perm_wut_prescaler;
          psc_rld_n = perm_wut_prescaler;
        end
        S_RUN: if (psc == '0) begin
          psc_n   = psc_rld;
          cnt_n   = cnt - 1'b1;
          state_n = (cnt == CNT_WIDTH'(1)) ? S_FIRE : S_RUN;
        end else begin
          psc_n = psc - 1'b1;
        end
        S_FIRE: begin
          state_n = S_IDLE;
          psc_n   = '0;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
  // ack and it are flopped from the next state so the PMU sees clean flop outputs
  always_ff @(posedge perm_clk or negedge perm_rstb) begin
    if (!perm_rstb) begin
      state              <= S_IDLE;
      cnt                <= '0;
      psc                <= '0;
      psc_rld            <= '0;
      perm_wut_start_ack <= 1'b0;
      perm_wut_it        <= 1'b0;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      psc                <= psc_n;
      psc_rld            <= psc_rld_n;
      perm_wut_start_ack <= state_n != S_IDLE;
      perm_wut_it        <= state_n == S_FIRE;
    end
  end
`ifdef WUT_READBACK_EN
  assign perm_wut_remaining = cnt;
`endif
endmodule
